// File: rtl/matmul_job_scheduler.sv
// Descriptor queue and single-issue job sequencer for the systolic array.
// Pops one job at a time, drives its operands, and reports a tagged status.
module matmul_job_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [15:0]            push_a_addr_i,
  input  logic [15:0]            push_b_addr_i,
  input  logic [15:0]            push_c_addr_i,
  input  logic [15:0]            push_m_i,
  input  logic [15:0]            push_n_i,
  input  logic [15:0]            push_p_i,
  input  logic [TAG_WIDTH-1:0]   push_tag_i,
  input  logic                   flush_i,
  output logic [15:0]            base_addr_a_o,
  output logic [15:0]            base_addr_b_o,
  output logic [15:0]            base_addr_c_o,
  output logic [15:0]            m_o,
  output logic [15:0]            n_o,
  output logic [15:0]            p_o,
  output logic                   start_o,
  input  logic                   done_i,
  output logic                   cpl_valid_o,
  input  logic                   cpl_ready_i,
  output logic [TAG_WIDTH-1:0]   cpl_tag_o,
  output logic [1:0]             cpl_status_o,
  output logic                   busy_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [15:0]          a;
    logic [15:0]          b;
    logic [15:0]          c;
    logic [15:0]          m;
    logic [15:0]          n;
    logic [15:0]          p;
    logic [TAG_WIDTH-1:0] tag;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    CPL
  } state_t;

  desc_t         mem [QUEUE_DEPTH];
  desc_t         head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [31:0]   timer;
  logic          done_d;
  logic          push;
  logic          pop;
  logic          rise;

  assign push_ready_o  = (count < CW'(QUEUE_DEPTH)) && !flush_i;
  assign push          = push_valid_i && push_ready_o;
  assign pop           = (state == IDLE) && (count != '0) && !flush_i;
  assign head          = mem[rd_ptr];
  assign rise          = done_i && !done_d;
  assign busy_o        = (state != IDLE) || (count != '0);
  assign queue_count_o = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: push_a_addr_i, b: push_b_addr_i,
                       c: push_c_addr_i, m: push_m_i,
                       n: push_n_i, p: push_p_i,
                       tag: push_tag_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      done_d        <= 1'b0;
      start_o       <= 1'b0;
      cpl_valid_o   <= 1'b0;
      cpl_tag_o     <= '0;
      cpl_status_o  <= 2'b00;
      base_addr_a_o <= '0;
      base_addr_b_o <= '0;
      base_addr_c_o <= '0;
      m_o           <= '0;
      n_o           <= '0;
      p_o           <= '0;
    end else begin
      done_d <= done_i;
      unique case (state)
        IDLE: begin
          if (pop) begin
            base_addr_a_o <= head.a;
            base_addr_b_o <= head.b;
            base_addr_c_o <= head.c;
            m_o           <= head.m;
            n_o           <= head.n;
            p_o           <= head.p;
            cpl_tag_o     <= head.tag;
            // zero-sized jobs complete as invalid without touching the array
            if (head.m == '0 || head.n == '0 || head.p == '0) begin
              cpl_status_o <= 2'b10;
              cpl_valid_o  <= 1'b1;
              state        <= CPL;
            end else begin
              start_o <= 1'b1;
              state   <= START;
            end
          end
        end
        START: begin
          start_o <= 1'b0;
          timer   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          timer <= timer + 32'd1;
          if (rise) begin
            cpl_status_o <= 2'b00;
            cpl_valid_o  <= 1'b1;
            state        <= CPL;
          end else if (TIMEOUT_CYCLES != 0 && timer == TLIM) begin
            cpl_status_o <= 2'b01;
            cpl_valid_o  <= 1'b1;
            state        <= CPL;
          end
        end
        CPL: begin
          if (cpl_ready_i) begin
            cpl_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
